// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - 8-bit audio PWM output with sample FIFO
// One duty sample is consumed per 256-cycle PWM period, taken at the last count of the period.
module audio_pwm_out #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_LEVEL = 8'h80
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        en_i,
  input  logic                        sample_valid_i,
  input  logic [7:0]                  sample_data_i,
  output logic                        sample_ready_o,
  output logic                        pwm_o,
  output logic                        period_start_o,
  output logic                        underrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  logic [7:0]    r_cnt;
  logic [7:0]    r_duty;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_live;

  logic w_en;
  logic w_full;
  logic w_empty;
  logic w_wrap;
  logic w_push;
  logic w_pop;
  logic w_underrun;

  // r_live holds the block quiet for the first cycle after reset, whatever en_i says.
  assign w_en       = en_i & rstn_i & r_live;
  assign w_full     = (r_level == FULL_LEVEL);
  assign w_empty    = (r_level == '0);
  assign w_wrap     = (r_cnt == 8'hFF);
  assign w_push     = w_en & sample_valid_i & ~w_full;
  assign w_pop      = w_en & w_wrap & ~w_empty;
  assign w_underrun = w_en & w_wrap & w_empty;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_live   <= 1'b0;
      r_cnt    <= 8'd0;
      r_duty   <= IDLE_LEVEL;
      r_level  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_live <= 1'b1;
      if (!w_en) begin
        r_cnt    <= 8'd0;
        r_duty   <= IDLE_LEVEL;
        r_level  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
        if (w_pop) begin
          r_duty   <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level alone.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_data_i;
    end
  end

  assign sample_ready_o = w_en & ~w_full;
  assign pwm_o          = w_en & (r_cnt < r_duty);
  assign period_start_o = w_en & (r_cnt == 8'd0);
  assign underrun_o     = w_underrun;
  assign fifo_level_o   = rstn_i ? r_level : '0;

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb/tb_audio_pwm_out.sv - directed bench for audio_pwm_out
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_audio_pwm_out;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       pwm;
  logic       ps;
  logic       ur;
  logic [2:0] level;

  int n_vec  = 0;
  int n_miss = 0;

  audio_pwm_out #(.FIFO_DEPTH(4), .IDLE_LEVEL(8'h80)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .en_i           (en),
    .sample_valid_i (valid),
    .sample_data_i  (data),
    .sample_ready_o (ready),
    .pwm_o          (pwm),
    .period_start_o (ps),
    .underrun_o     (ur),
    .fifo_level_o   (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n, output int hi, output int pst, output int urc,
                            output int ur_idx, output logic last_pwm);
    hi = 0; pst = 0; urc = 0; ur_idx = -1; last_pwm = 1'bx;
    for (int i = 0; i < n; i++) begin
      #1;
      hi  += int'(pwm);
      pst += int'(ps);
      if (ur) begin
        urc++;
        ur_idx = i;
      end
      last_pwm = pwm;
      tick();
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_pwm"},   pwm,   0);
    chk({tag, "_ps"},    ps,    0);
    chk({tag, "_ur"},    ur,    0);
    chk({tag, "_level"}, level, 0);
  endtask

  int         hi, pst, urc, uidx;
  logic       lp;
  logic [7:0] d6 [6];
  int         acc [6];
  int         hp [3];
  int         idx;

  initial begin
    d6[0] = 8'h10; d6[1] = 8'h20; d6[2] = 8'h30;
    d6[3] = 8'h40; d6[4] = 8'h50; d6[5] = 8'h60;

    // reset overrides an asserted enable and a valid sample
    rstn = 1'b0; en = 1'b1; valid = 1'b1; data = 8'h55;
    @(negedge clk);
    @(negedge clk);
    #1 check_quiet("rst");
    rstn = 1'b0;
    valid = 1'b0;
    rstn = 1'b1;
    #1 check_quiet("post_rst");
    tick();
    #1 chk("first_ps", ps, 1);
    chk("first_pwm", pwm, 1);
    chk("first_ready", ready, 1);

    // idle duty with no samples
    for (int p = 0; p < 2; p++) begin
      run_cycles(256, hi, pst, urc, uidx, lp);
      chk("idle_hi", hi, 128);
      chk("idle_ps", pst, 1);
      chk("idle_ur", urc, 1);
      chk("idle_ur_idx", uidx, 255);
    end

    // two samples, one period each
    valid = 1'b1; data = 8'h40;
    #1 chk("p1_lvl0", level, 0);
    tick();
    data = 8'hC0;
    #1 chk("p1_lvl1", level, 1);
    tick();
    valid = 1'b0;
    #1 chk("p1_lvl2", level, 2);
    run_cycles(254, hi, pst, urc, uidx, lp);
    chk("p1_ur", urc, 0);
    #1 chk("p2_lvl", level, 1);
    run_cycles(256, hi, pst, urc, uidx, lp);
    chk("p2_hi", hi, 64);
    chk("p2_ur", urc, 0);
    #1 chk("p3_lvl", level, 0);
    run_cycles(256, hi, pst, urc, uidx, lp);
    chk("p3_hi", hi, 192);
    chk("p3_ur", urc, 1);

    // boundary duties
    valid = 1'b1; data = 8'h00;
    tick();
    data = 8'hFF;
    tick();
    valid = 1'b0;
    run_cycles(254, hi, pst, urc, uidx, lp);
    run_cycles(256, hi, pst, urc, uidx, lp);
    chk("d00_hi", hi, 0);
    run_cycles(256, hi, pst, urc, uidx, lp);
    chk("dff_hi", hi, 255);
    chk("dff_last", lp, 0);

    // back-to-back producer against a 4-deep FIFO
    idx = 0;
    for (int k = 0; k < 6; k++) acc[k] = -1;
    for (int k = 0; k < 3; k++) hp[k] = 0;
    for (int c = 0; c < 768; c++) begin
      valid = (idx < 6);
      data  = (idx < 6) ? d6[idx] : 8'h00;
      #1;
      if (c == 4) begin
        chk("full_ready", ready, 0);
        chk("full_level", level, 4);
      end
      if (c == 255) begin
        chk("pop_ready", ready, 0);
        chk("pop_level", level, 4);
      end
      hp[c / 256] += int'(pwm);
      if (valid && ready) begin
        acc[idx] = c;
        idx++;
      end
      tick();
    end
    valid = 1'b0;
    chk("acc3", acc[3], 3);
    chk("acc4", acc[4], 256);
    chk("acc5", acc[5], 512);
    chk("bb_hi0", hp[0], 255);
    chk("bb_hi1", hp[1], 16);
    chk("bb_hi2", hp[2], 32);
    #1 chk("bb_level", level, 3);

    // disable mid-period with three queued
    run_cycles(100, hi, pst, urc, uidx, lp);
    en = 1'b0;
    #1 chk("dis_pwm", pwm, 0);
    chk("dis_ready", ready, 0);
    tick();
    #1 check_quiet("dis");
    for (int k = 0; k < 9; k++) tick();
    en = 1'b1;
    #1 chk("reen_ps", ps, 1);
    chk("reen_level", level, 0);
    run_cycles(256, hi, pst, urc, uidx, lp);
    chk("reen_hi", hi, 128);
    chk("reen_ur_idx", uidx, 255);

    // same case with a mid-period reset
    valid = 1'b1; data = 8'h11;
    tick();
    data = 8'h22;
    tick();
    data = 8'h33;
    tick();
    valid = 1'b0;
    #1 chk("rr_level", level, 3);
    run_cycles(97, hi, pst, urc, uidx, lp);
    rstn = 1'b0;
    #1 check_quiet("rr_in");
    for (int k = 0; k < 10; k++) tick();
    rstn = 1'b1;
    #1 check_quiet("rr_after");
    tick();
    #1 chk("rr_ps", ps, 1);
    chk("rr_level0", level, 0);
    run_cycles(256, hi, pst, urc, uidx, lp);
    chk("rr_hi", hi, 128);
    chk("rr_ur_idx", uidx, 255);

    // push coinciding with the period boundary
    valid = 1'b1; data = 8'h20;
    tick();
    valid = 1'b0;
    #1 chk("b_lvl1", level, 1);
    run_cycles(254, hi, pst, urc, uidx, lp);
    valid = 1'b1; data = 8'h60;
    #1 chk("b1_ready", ready, 1);
    chk("b1_ur", ur, 0);
    chk("b1_level", level, 1);
    tick();
    valid = 1'b0;
    #1 chk("b1_level_after", level, 1);
    run_cycles(255, hi, pst, urc, uidx, lp);
    chk("b1_hi", hi, 32);
    run_cycles(1, hi, pst, urc, uidx, lp);
    #1 chk("b0_lvl", level, 0);
    run_cycles(255, hi, pst, urc, uidx, lp);
    chk("b0_hi", hi, 96);
    valid = 1'b1; data = 8'h90;
    #1 chk("b0_ur", ur, 1);
    chk("b0_level", level, 0);
    tick();
    valid = 1'b0;
    #1 chk("b0_level_after", level, 1);
    run_cycles(255, hi, pst, urc, uidx, lp);
    chk("b0_hold_hi", hi, 96);
    run_cycles(1, hi, pst, urc, uidx, lp);
    run_cycles(256, hi, pst, urc, uidx, lp);
    chk("b0_next_hi", hi, 144);
    chk("b0_next_ur_idx", uidx, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sample buffer entries; power of two, 2..16.
REQ-002 Parameter IDLE_LEVEL, default 8'h80, duty applied after reset, while disabled, and before the first sample.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rstn_i  input  1  reset, synchronous, active-low.
REQ-005 en_i  input  1  block enable; 0 = idle/flush.
REQ-006 sample_valid_i  input  1  producer presents a sample.
REQ-007 sample_data_i  input  8  unsigned sample, from the mixer output.
REQ-008 sample_ready_o  output  1  block accepts a sample this cycle.
REQ-009 pwm_o  output  1  PWM audio output.
REQ-010 period_start_o  output  1  one-cycle pulse at PWM period start.
REQ-011 underrun_o  output  1  one-cycle pulse when a period boundary finds the FIFO empty.
REQ-012 fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-013 A sample transfers only on a cycle where sample_valid_i=1 and sample_ready_o=1.
- Producer holds data stable while valid=1 and ready=0.
REQ-014 sample_ready_o = en_i AND (level < FIFO_DEPTH).
- Level is the registered value; a pop in the same cycle does not raise ready.
REQ-015 The FIFO is first-in first-out and stores accepted samples.
- Push only: level+1. Pop only: level-1. Push and pop in the same cycle: level unchanged, data order preserved.
REQ-016 An 8-bit period counter cnt increments by 1 each cycle while en_i=1 and wraps 255->0.
- PWM period = 256 cycles.
REQ-017 pwm_o = en_i AND (cnt < duty), combinational from registered cnt and duty.
- duty 0: pwm_o constantly 0.
- duty 255: pwm_o high 255 of 256 cycles.
REQ-018 period_start_o = en_i AND (cnt == 0).
REQ-019 On a cycle with en_i=1 and cnt==255, and the FIFO non-empty: the head is popped into duty, effective from the next cycle (cnt==0).
REQ-020 On a cycle with en_i=1 and cnt==255, and the FIFO empty: duty keeps its value and underrun_o=1 for that cycle.
- A push in that same cycle is stored, not consumed.
REQ-021 Latency: a sample pushed into an empty FIFO drives pwm_o from the first cnt==0 that follows the next cnt==255 cycle.
REQ-022 While en_i=0:
- cnt=0, duty=IDLE_LEVEL, FIFO flushed (level 0).
- sample_ready_o=0, pwm_o=0, period_start_o=0, underrun_o=0.
REQ-023 On the first cycle with en_i=1 after en_i=0, cnt=0.
- period_start_o=1 on that cycle.
- The first period uses IDLE_LEVEL.
REQ-024 Deasserting en_i mid-period aborts the period with no pop and no underrun.
REQ-025 underrun_o and period_start_o are never asserted when en_i=0.

Reset
REQ-026 On a clock edge with rstn_i=0: cnt=0, duty=IDLE_LEVEL, FIFO level 0, FIFO storage contents don't-care.
REQ-027 Reset overrides en_i and every other input.
- Reset mid-period or with a non-empty FIFO discards all state.
REQ-028 While rstn_i=0 and on the first cycle after it, all outputs are 0 and fifo_level_o=0.

Verification
REQ-029 Reset, then en_i=1 with no samples:
- period_start_o pulses every 256 cycles.
- pwm_o high 128 of 256 cycles.
- underrun_o pulses at each cnt==255.
REQ-030 Push 8'h40 then 8'hC0 while enabled:
- Period 2 shows pwm_o high for 64 cycles and period 3 for 192 cycles.
- fifo_level_o steps 1,2,1,0.
REQ-031 Push 6 samples back-to-back into FIFO_DEPTH=4:
- sample_ready_o drops after the 4th; fifo_level_o=4.
- The 5th is held by the producer until the pop at cnt==255, accepted the next cycle.
REQ-032 Boundary duties: push 8'h00, 8'hFF.
- pwm_o=0 for a whole period, then high for 255 cycles and low 1 cycle.
REQ-033 Level 1 at the cnt==255 cycle with a simultaneous push:
- Pop and push occur and level stays 1.
- With level 0 instead: underrun_o=1 and level becomes 1.
REQ-034 Drop en_i at cnt=100 with 3 queued; re-enable 10 cycles later:
- The disable flushes the FIFO and forces pwm_o=0.
- On re-enable cnt restarts at 0 with duty 8'h80.
- Repeat the case with rstn_i=0 at cnt=100 and expect the same result.
